apb_slave_if: RTL

- APB3 slave front-end for the ECC encoder/decoder; sits directly upstream of the register bank.
- Runs the APB handshake (PSEL/PENABLE/PREADY/PSLVERR) and converts each accepted transfer into a single-cycle bank write strobe or a registered bank read.
- Owns a local STATUS register at offset 0x10.
- Stalls CTRL writes while the core is busy, rejects illegal addresses and values, and issues a one-cycle op_start to the core.

---
 rtl/apb_slave_if.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_slave_if.sv
// apb_slave_if
// APB3 slave front-end for the ECC encoder/decoder register bank.
// It runs the APB handshake and turns each accepted transfer into either a
// single-cycle bank write strobe or a registered bank read. It also owns the
// read-only STATUS register at offset 0x10. CTRL (0x0) writes are held off
// while the core is busy, and each accepted CTRL write sends op_start to the core.
//
// Ports
//   clk, rst        system clock, asynchronous active-low reset
//   PSEL/PENABLE    APB select / enable
//   PWRITE          1 = write, 0 = read
//   PADDR, PWDATA   APB byte address and write data
//   PRDATA          registered read data (held until the next read completes)
//   PREADY          registered transfer-complete, high for one cycle
//   PSLVERR         registered error, only meaningful while PREADY = 1
//   bank_write      one-cycle write strobe to the register bank
//   bank_addr       latched transfer address
//   bank_wdata      latched write data
//   bank_rdata      combinational read data from the register bank
//   core_busy       ECC core operation in progress
//   core_done       one-cycle pulse when a core operation ends
//   op_start        one-cycle start pulse to the core
module apb_slave_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int STALL_TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic                       bank_write,
    output logic [AMBA_ADDR_WIDTH-1:0] bank_addr,
    output logic [AMBA_WORD-1:0]       bank_wdata,
    input  logic [AMBA_WORD-1:0]       bank_rdata,
    input  logic                       core_busy,
    input  logic                       core_done,
    output logic                       op_start
);

    localparam int               CNT_W      = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [4:0]       OFF_CTRL   = 5'h00;
    localparam logic [4:0]       OFF_08     = 5'h08;
    localparam logic [4:0]       OFF_STATUS = 5'h10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        STALL,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [AMBA_ADDR_WIDTH-1:0] addrLatch_q;
    logic [AMBA_WORD-1:0]       wdataLatch_q;
    logic                       writeLatch_q;
    logic [AMBA_WORD-1:0]       prdata_q, prdata_d;
    logic                       pready_q, pready_d;
    logic                       pslverr_q, pslverr_d;
    logic                       opStart_q, opStart_d;
    logic [CNT_W-1:0]           stallCnt_q, stallCnt_d;
    logic                       statusDone_q;
    logic                       latchEn;
    logic                       bankWrite;

    logic [4:0]                 addrOff;
    logic                       addrErr;
    logic                       dataErr;
    logic                       xferErr;
    logic                       isCtrl;
    logic                       isStatus;
    logic                       statusClr;
    logic [AMBA_WORD-1:0]       statusWord;

    // Decode the latched transfer. Only word-aligned offsets 0x0-0x10 with all
    // upper address bits clear are legal. STATUS is read-only. CTRL must not
    // receive mode 2'b11, and register 0x8 only accepts values 0..2.
    always_comb begin
        addrOff    = addrLatch_q[4:0];
        isCtrl     = (addrOff == OFF_CTRL);
        isStatus   = (addrOff == OFF_STATUS);
        addrErr    = (addrLatch_q[1:0] != 2'b00)
                   || (addrLatch_q[AMBA_ADDR_WIDTH-1:5] != '0)
                   || (addrOff > OFF_STATUS);
        dataErr    = writeLatch_q
                   && (isStatus
                       || (isCtrl && (wdataLatch_q[1:0] == 2'b11))
                       || ((addrOff == OFF_08) && (wdataLatch_q > AMBA_WORD'(2))));
        xferErr    = addrErr || dataErr;
        statusWord = {{(AMBA_WORD-2){1'b0}}, core_busy, statusDone_q};
    end

    // Next-state logic. PREADY, PSLVERR and op_start are computed one cycle
    // early and then registered, so they appear together in the DONE cycle.
    always_comb begin
        state_d    = state_q;
        prdata_d   = prdata_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        opStart_d  = 1'b0;
        stallCnt_d = stallCnt_q;
        bankWrite  = 1'b0;
        latchEn    = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    latchEn = 1'b1;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (xferErr) begin
                    state_d   = DONE;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else if (writeLatch_q) begin
                    if (isCtrl && core_busy) begin
                        state_d    = STALL;
                        stallCnt_d = '0;
                    end else begin
                        bankWrite = 1'b1;
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        opStart_d = isCtrl;
                    end
                end else begin
                    state_d  = DONE;
                    pready_d = 1'b1;
                    prdata_d = isStatus ? statusWord : bank_rdata;
                end
            end

            // A stalled CTRL write completes as soon as the core goes idle,
            // even on the last allowed cycle, before the timeout is considered.
            STALL: begin
                if (!core_busy) begin
                    bankWrite = 1'b1;
                    state_d   = DONE;
                    pready_d  = 1'b1;
                    opStart_d = 1'b1;
                end else if (stallCnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else if (!PSEL) begin
                    state_d = IDLE;
                end else begin
                    stallCnt_d = stallCnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and APB output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            opStart_q  <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            opStart_q  <= opStart_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Transfer latches, captured in the setup cycle and held for the whole
    // transfer so the bank sees a stable address and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrLatch_q  <= '0;
            wdataLatch_q <= '0;
            writeLatch_q <= 1'b0;
        end else if (latchEn) begin
            addrLatch_q  <= PADDR;
            wdataLatch_q <= PWDATA;
            writeLatch_q <= PWRITE;
        end
    end

    // STATUS.done is cleared by a successful STATUS read. A core_done pulse in
    // that same cycle takes priority, so no completion is lost.
    assign statusClr = (state_q == DONE) && !writeLatch_q && isStatus && !pslverr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statusDone_q <= 1'b0;
        end else if (core_done) begin
            statusDone_q <= 1'b1;
        end else if (statusClr) begin
            statusDone_q <= 1'b0;
        end
    end

    assign PRDATA     = prdata_q;
    assign PREADY     = pready_q;
    assign PSLVERR    = pslverr_q;
    assign op_start   = opStart_q;
    assign bank_write = bankWrite;
    assign bank_addr  = addrLatch_q;
    assign bank_wdata = wdataLatch_q;

endmodule
